// File: rtl/o_serdes_pkg.sv
// Shared constants, beat payload and tap stepping for the output serializer.
package o_serdes_pkg;

  localparam int unsigned WIDTH_MIN = 3;
  localparam int unsigned WIDTH_MAX = 10;
  localparam int unsigned TAP_MAX   = 63;
  localparam int unsigned TAP_W     = 6;

  typedef struct packed {
    logic oe;
    logic odd;
    logic even;
  } beat_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ser_state_t;

  // One saturating tap step up or down.
  function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap, input logic inc);
    if (inc) begin
      return (tap == TAP_W'(TAP_MAX)) ? tap : tap + TAP_W'(1);
    end
    return (tap == '0) ? tap : tap - TAP_W'(1);
  endfunction

endpackage

// File: rtl/o_serdes_delay.sv
// Programmable output tap delay: tap register with load/step control and a beat delay line.
module o_delay
  import o_serdes_pkg::*;
#(
  parameter int unsigned DELAY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adj,
  input  logic             incdec,
  input  beat_t            src,
  output beat_t            dly_c,
  output logic [TAP_W-1:0] tap
);

  logic [TAP_W-1:0]           tap_q;
  logic                       adj_q;
  beat_t [TAP_MAX-1:0]        line_q;

  // Reload has priority over a rising-edge step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_q <= TAP_W'(DELAY);
      adj_q <= 1'b0;
    end else begin
      adj_q <= adj;
      if (load) begin
        tap_q <= TAP_W'(DELAY);
      end else if (adj && !adj_q) begin
        tap_q <= tap_step(tap_q, incdec);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= {line_q[TAP_MAX-2:0], src};
    end
  end

  // Tap 0 passes the registered beat straight through.
  always_comb begin
    dly_c = src;
    if (tap_q != '0) begin
      dly_c = line_q[tap_q - TAP_W'(1)];
    end
  end

  assign tap = tap_q;

endmodule

// File: rtl/o_serdes.sv
// Parallel-to-serial output serializer (SDR/DDR) with optional tap delay and lane word alignment.
module o_serdes
  import o_serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter string       DATA_RATE = "SDR",
  parameter string       EN_ODLY   = "FALSE",
  parameter int unsigned DELAY     = 0
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  input  logic             PLL_LOCK,
  input  logic             OE_IN,
  output logic             OE_OUT,
  input  logic             CHANNEL_BOND_SYNC_IN,
  output logic             CHANNEL_BOND_SYNC_OUT,
  input  logic             DLY_LOAD,
  input  logic             DLY_ADJ,
  input  logic             DLY_INCDEC,
  output logic [TAP_W-1:0] DLY_TAP_VALUE,
  output logic             Q
);

  localparam bit          IS_DDR  = (DATA_RATE == "DDR");
  localparam bit          USE_DLY = (EN_ODLY == "TRUE");
  localparam int unsigned BEATS   = IS_DDR ? (WIDTH + 1) / 2 : WIDTH;
  localparam int unsigned STEP    = IS_DDR ? 2 : 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SH_W    = WIDTH + 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "o_serdes: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (DATA_RATE != "SDR" && DATA_RATE != "DDR") begin : g_bad_rate
    $fatal(1, "o_serdes: DATA_RATE must be SDR or DDR");
  end
  if (DELAY > TAP_MAX) begin : g_bad_delay
    $fatal(1, "o_serdes: DELAY %0d above %0d", DELAY, TAP_MAX);
  end

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  beat_t            out_q, cur_c, line_c;
  logic             sync_q, first_c, last_c, load_c, live_c;

  always_ff @(posedge CLK_IN) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sh_q    <= sh_d;
      out_q   <= cur_c;
      sync_q  <= first_c;
    end
  end

  // Word load, beat sequencing and the bit pair presented for registration.
  // The shifter carries D[WIDTH-1] twice so an odd-width DDR word repeats its MSB.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    sh_d    = sh_q;
    cur_c   = '0;
    first_c = 1'b0;
    live_c  = (state_q == ST_RUN) && PLL_LOCK;
    last_c  = (beat_q == CNT_W'(BEATS - 1));
    load_c  = PLL_LOCK && DATA_VALID &&
              (CHANNEL_BOND_SYNC_IN || state_q == ST_IDLE || last_c);

    if (live_c) begin
      cur_c.even = sh_q[0];
      cur_c.odd  = IS_DDR ? sh_q[1] : sh_q[0];
      first_c    = (beat_q == '0);
    end
    cur_c.oe = OE_IN;

    if (!PLL_LOCK) begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end else if (load_c) begin
      state_d = ST_RUN;
      beat_d  = '0;
      sh_d    = {D[WIDTH-1], D};
    end else if (CHANNEL_BOND_SYNC_IN || (state_q == ST_RUN && last_c)) begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end else if (state_q == ST_RUN) begin
      beat_d = beat_q + CNT_W'(1);
      sh_d   = sh_q >> STEP;
    end
  end

  if (USE_DLY) begin : g_dly
    o_delay #(.DELAY(DELAY)) u_dly (
      .clk    (CLK_IN),
      .rst_n  (RST),
      .load   (DLY_LOAD),
      .adj    (DLY_ADJ),
      .incdec (DLY_INCDEC),
      .src    (out_q),
      .dly_c  (line_c),
      .tap    (DLY_TAP_VALUE)
    );
  end else begin : g_bypass
    logic unused_dly;
    assign unused_dly    = ^{DLY_LOAD, DLY_ADJ, DLY_INCDEC};
    assign line_c        = out_q;
    assign DLY_TAP_VALUE = TAP_W'(DELAY);
  end

  // In SDR both slots hold the same bit, so the clock-level mux is transparent.
  assign Q                     = CLK_IN ? line_c.even : line_c.odd;
  assign OE_OUT                = line_c.oe;
  assign CHANNEL_BOND_SYNC_OUT = sync_q;

endmodule

// File: tb/tb_o_serdes.sv
// Bench for o_serdes: five configurations share one stimulus and are checked against a beat-queue model.
module tb_o_serdes;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst, valid, pll, oe, sync, dly_load, dly_adj, dly_inc;
  logic [9:0] d;
  logic       q_o [5];
  logic       so_o [5];
  logic       oe_o [5];
  logic [5:0] tap_o [5];

  always #5 clk = ~clk;

  o_serdes #(.WIDTH(4)) u0 (
    .CLK_IN(clk), .RST(rst), .D(d[3:0]), .DATA_VALID(valid), .PLL_LOCK(pll),
    .OE_IN(oe), .OE_OUT(oe_o[0]), .CHANNEL_BOND_SYNC_IN(sync), .CHANNEL_BOND_SYNC_OUT(so_o[0]),
    .DLY_LOAD(dly_load), .DLY_ADJ(dly_adj), .DLY_INCDEC(dly_inc), .DLY_TAP_VALUE(tap_o[0]), .Q(q_o[0]));
  o_serdes #(.WIDTH(8), .DATA_RATE("DDR")) u1 (
    .CLK_IN(clk), .RST(rst), .D(d[7:0]), .DATA_VALID(valid), .PLL_LOCK(pll),
    .OE_IN(oe), .OE_OUT(oe_o[1]), .CHANNEL_BOND_SYNC_IN(sync), .CHANNEL_BOND_SYNC_OUT(so_o[1]),
    .DLY_LOAD(dly_load), .DLY_ADJ(dly_adj), .DLY_INCDEC(dly_inc), .DLY_TAP_VALUE(tap_o[1]), .Q(q_o[1]));
  o_serdes #(.WIDTH(10)) u2 (
    .CLK_IN(clk), .RST(rst), .D(d[9:0]), .DATA_VALID(valid), .PLL_LOCK(pll),
    .OE_IN(oe), .OE_OUT(oe_o[2]), .CHANNEL_BOND_SYNC_IN(sync), .CHANNEL_BOND_SYNC_OUT(so_o[2]),
    .DLY_LOAD(dly_load), .DLY_ADJ(dly_adj), .DLY_INCDEC(dly_inc), .DLY_TAP_VALUE(tap_o[2]), .Q(q_o[2]));
  o_serdes #(.WIDTH(3), .DATA_RATE("DDR")) u3 (
    .CLK_IN(clk), .RST(rst), .D(d[2:0]), .DATA_VALID(valid), .PLL_LOCK(pll),
    .OE_IN(oe), .OE_OUT(oe_o[3]), .CHANNEL_BOND_SYNC_IN(sync), .CHANNEL_BOND_SYNC_OUT(so_o[3]),
    .DLY_LOAD(dly_load), .DLY_ADJ(dly_adj), .DLY_INCDEC(dly_inc), .DLY_TAP_VALUE(tap_o[3]), .Q(q_o[3]));
  o_serdes #(.WIDTH(4), .EN_ODLY("TRUE"), .DELAY(5)) u4 (
    .CLK_IN(clk), .RST(rst), .D(d[3:0]), .DATA_VALID(valid), .PLL_LOCK(pll),
    .OE_IN(oe), .OE_OUT(oe_o[4]), .CHANNEL_BOND_SYNC_IN(sync), .CHANNEL_BOND_SYNC_OUT(so_o[4]),
    .DLY_LOAD(dly_load), .DLY_ADJ(dly_adj), .DLY_INCDEC(dly_inc), .DLY_TAP_VALUE(tap_o[4]), .Q(q_o[4]));

  // Reference model: per instance a list of pending beats {first, odd, even}.
  logic [2:0] mq [NI][16];
  int         mq_n [NI];
  logic       exp_e [NI], exp_o [NI], exp_s [NI];
  logic       exp_oe;
  logic [2:0] hist [64];
  int         m_tap;
  logic       m_adj_prev;
  int         n_cmp = 0, n_err = 0;
  bit         armed = 1'b0;
  logic [4:0] hi_s, lo_s, sy_s;

  function automatic int wid(input int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : (i == 2) ? 10 : 3;
  endfunction

  function automatic bit is_ddr(input int i);
    return (i == 1) || (i == 3);
  endfunction

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s[%0d] at %0t: got %0h expected %0h", tag, idx, $time, obs, expv);
    end
  endtask

  task automatic push_word(input int i);
    int   w, nb;
    logic e, o;
    w  = wid(i);
    nb = is_ddr(i) ? (w + 1) / 2 : w;
    for (int b = 0; b < nb; b++) begin
      if (is_ddr(i)) begin
        e = d[2*b];
        o = (2*b + 1 < w) ? d[2*b+1] : d[w-1];
      end else begin
        e = d[b];
        o = d[b];
      end
      mq[i][mq_n[i]] = {(b == 0), o, e};
      mq_n[i]++;
    end
  endtask

  // Apply the inputs present at this rising edge to the model.
  task automatic model_edge();
    bit free;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        mq_n[i] = 0; exp_e[i] = 1'b0; exp_o[i] = 1'b0; exp_s[i] = 1'b0;
      end
      for (int k = 0; k < 64; k++) hist[k] = 3'b000;
      exp_oe     = 1'b0;
      m_tap      = 5;
      m_adj_prev = 1'b0;
      armed      = 1'b1;
      return;
    end
    for (int i = 0; i < NI; i++) begin
      free = (mq_n[i] <= 1);
      if (pll && mq_n[i] > 0) begin
        {exp_s[i], exp_o[i], exp_e[i]} = mq[i][0];
        for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
        mq_n[i]--;
      end else begin
        exp_s[i] = 1'b0; exp_o[i] = 1'b0; exp_e[i] = 1'b0;
      end
      if (!pll) mq_n[i] = 0;
      else if (sync) begin
        mq_n[i] = 0;
        if (valid) push_word(i);
      end else if (valid && free) push_word(i);
    end
    exp_oe = oe;
    if (dly_load) m_tap = 5;
    else if (dly_adj && !m_adj_prev) m_tap = dly_inc ? ((m_tap < 63) ? m_tap + 1 : 63)
                                                     : ((m_tap > 0) ? m_tap - 1 : 0);
    m_adj_prev = dly_adj;
    for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {exp_oe, exp_o[0], exp_e[0]};
  endtask

  task automatic low_checks();
    for (int i = 0; i < NI; i++) begin
      chk("q_low", i, 8'(q_o[i]), 8'(is_ddr(i) ? exp_o[i] : exp_e[i]));
      lo_s[i] = q_o[i];
    end
    chk("q_low", 4, 8'(q_o[4]), 8'(hist[m_tap][1]));
    lo_s[4] = q_o[4];
  endtask

  task automatic high_checks();
    for (int i = 0; i < NI; i++) begin
      chk("q_high", i, 8'(q_o[i]), 8'(exp_e[i]));
      chk("sync_out", i, 8'(so_o[i]), 8'(exp_s[i]));
      chk("oe_out", i, 8'(oe_o[i]), 8'(exp_oe));
      chk("tap", i, 8'(tap_o[i]), 8'd0);
      hi_s[i] = q_o[i];
      sy_s[i] = so_o[i];
    end
    chk("q_high", 4, 8'(q_o[4]), 8'(hist[m_tap][0]));
    chk("oe_out", 4, 8'(oe_o[4]), 8'(hist[m_tap][2]));
    chk("sync_out", 4, 8'(so_o[4]), 8'(exp_s[0]));
    chk("tap", 4, 8'(tap_o[4]), 8'(m_tap));
    hi_s[4] = q_o[4];
    sy_s[4] = so_o[4];
  endtask

  // One clock: low-phase check with the new inputs applied, edge, high-phase check.
  task automatic tick();
    #1;
    if (armed) low_checks();
    @(posedge clk);
    model_edge();
    #1;
    if (armed) high_checks();
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] t1_bits;
    logic [7:0] hi_tab, lo_tab;
    int         sc;
    rst = 1'b0; d = '0; valid = 1'b0; pll = 1'b1; oe = 1'b0; sync = 1'b0;
    dly_load = 1'b0; dly_adj = 1'b0; dly_inc = 1'b0;
    tick(); tick();
    chk("rst_tap", 4, 8'(tap_o[4]), 8'd5);
    chk("rst_q", 0, 8'(hi_s), 8'd0);
    rst = 1'b1;
    tick();

    // SDR W4: 1011 -> 1,1,0,1 then idle, one sync pulse.
    t1_bits = 5'b01011;
    d = 10'h00B; valid = 1'b1; tick(); valid = 1'b0;
    sc = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t1_q", j, 8'(hi_s[0]), 8'(t1_bits[j]));
      sc += int'(sy_s[0]);
    end
    chk("t1_sync", 0, 8'(sc), 8'd1);

    // DDR W8: A5 then 3C loaded on the final beat, gapless.
    hi_tab = 8'b01100011;
    lo_tab = 8'b01101100;
    d = 10'h0A5; valid = 1'b1; tick(); valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j == 3) begin d = 10'h03C; valid = 1'b1; end
      tick();
      valid = 1'b0;
      if (j > 0) chk("t2_lo", j - 1, 8'(lo_s[1]), 8'(lo_tab[j-1]));
      if (j < 8) begin
        chk("t2_hi", j, 8'(hi_s[1]), 8'(hi_tab[j]));
        chk("t2_sync", j, 8'(sy_s[1]), 8'((j == 0) || (j == 4)));
      end
    end

    // SDR W10: PLL_LOCK dropped after two beats.
    for (int j = 0; j < 12; j++) tick();
    d = 10'h3FF; valid = 1'b1; tick(); valid = 1'b0;
    tick(); chk("t3_beat", 0, 8'(hi_s[2]), 8'd1);
    tick(); chk("t3_beat", 1, 8'(hi_s[2]), 8'd1);
    pll = 1'b0; valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t3_unlock", j, 8'(hi_s[2]), 8'd0);
    end
    pll = 1'b1; valid = 1'b0;
    tick(); chk("t3_relock", 0, 8'(hi_s[2]), 8'd0);

    // DDR W3: channel-bond sync mid-word restarts with 110.
    d = 10'h003; valid = 1'b1; tick();
    d = 10'h006; sync = 1'b1; tick(); sync = 1'b0; valid = 1'b0;
    chk("t4_old", 0, 8'(hi_s[3]), 8'd1);
    tick();
    chk("t4_hi", 0, 8'(hi_s[3]), 8'd0);
    chk("t4_sync", 0, 8'(sy_s[3]), 8'd1);
    tick();
    chk("t4_lo", 0, 8'(lo_s[3]), 8'd1);
    chk("t4_hi", 1, 8'(hi_s[3]), 8'd1);
    chk("t4_sync", 1, 8'(sy_s[3]), 8'd0);
    tick();
    chk("t4_lo", 1, 8'(lo_s[3]), 8'd1);

    // Tap 5: delayed Q and OE lag the bypass path by five cycles.
    for (int j = 0; j < 10; j++) tick();
    oe = 1'b1; d = 10'h001; valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      valid = 1'b0;
      chk("t5_q", j, 8'(hi_s[4]), 8'(j == 6));
      chk("t5_oe", j, 8'(oe_o[4]), 8'(j >= 5));
    end

    // Tap control: three decrements, reload, saturating increments.
    dly_inc = 1'b0;
    for (int j = 0; j < 3; j++) begin
      dly_adj = 1'b1; tick(); dly_adj = 1'b0; tick();
    end
    chk("t6_dec", 4, 8'(tap_o[4]), 8'd2);
    dly_load = 1'b1; tick(); dly_load = 1'b0;
    chk("t6_load", 4, 8'(tap_o[4]), 8'd5);
    dly_inc = 1'b1;
    for (int j = 0; j < 70; j++) begin
      dly_adj = 1'b1; tick(); dly_adj = 1'b0; tick();
    end
    chk("t6_sat", 4, 8'(tap_o[4]), 8'd63);

    // Synchronous reset mid-word.
    d = 10'h3FF; valid = 1'b1; tick(); valid = 1'b0;
    tick();
    rst = 1'b0; tick();
    chk("t7_pre", 0, 8'(lo_s[0]), 8'd1);
    chk("t7_q", 0, 8'(hi_s), 8'd0);
    chk("t7_sync", 0, 8'(sy_s), 8'd0);
    chk("t7_oe", 4, 8'(oe_o[4]), 8'd0);
    chk("t7_tap", 4, 8'(tap_o[4]), 8'd5);
    rst = 1'b1;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 99) != 0);
      d        = 10'($urandom);
      valid    = ($urandom_range(0, 3) != 0);
      pll      = ($urandom_range(0, 24) != 0);
      sync     = ($urandom_range(0, 15) == 0);
      oe       = 1'($urandom);
      dly_load = ($urandom_range(0, 40) == 0);
      dly_adj  = 1'($urandom);
      dly_inc  = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
